// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares the write_fifo write port among NUM_REQ producers.
// Grants bounded bursts and never writes while the FIFO reports almost_full or full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int BC_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk_w,
  input  logic                      rst_w,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      almost_full,
  input  logic                      full,
  output logic                      w_en,
  output logic [DATA_W-1:0]         w_data,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      burst_done,
  output logic [CNT_W-1:0]          word_count
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [BC_W-1:0] burst_cnt;

  logic            stall;
  logic            xfer;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  int              idx;

  assign stall = almost_full | full;
  assign busy  = (state == BURST);
  assign xfer  = busy && req_valid[grant_id] && !stall;

  // Data path to the FIFO is combinational so an accepted word lands in the same cycle.
  always_comb begin
    w_en      = xfer;
    w_data    = '0;
    req_ready = '0;
    if (busy) begin
      w_data = req_data[int'(grant_id)*DATA_W +: DATA_W];
      if (!stall) req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[ID_W'(idx)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_w or negedge rst_w) begin
    if (!rst_w) begin
      state      <= IDLE;
      grant_id   <= '0;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      word_count <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found && !stall) begin
            grant_id  <= pick_id;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (word_count != '1) word_count <= word_count + 1'b1;
          end
          // A stall alone keeps the grant; only burst length or a dropped valid ends it.
          if ((xfer && burst_cnt == BC_W'(MAX_BURST - 1)) || !req_valid[grant_id]) begin
            state      <= IDLE;
            rr_ptr     <= grant_id;
            burst_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenarios plus random traffic, compared every cycle against a behavioural model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 6;
  localparam int IW = $clog2(N);

  logic            clk_w = 1'b0;
  logic            rst_w;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            almost_full;
  logic            full;
  logic            w_en;
  logic [DW-1:0]   w_data;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic            burst_done;
  logic [CW-1:0]   word_count;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk_w(clk_w), .rst_w(rst_w), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .almost_full(almost_full), .full(full), .w_en(w_en),
    .w_data(w_data), .busy(busy), .grant_id(grant_id), .burst_done(burst_done),
    .word_count(word_count)
  );

  always #5 clk_w = ~clk_w;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: who owns the port, how many words it has sent, who won last.
  int m_owner;
  int m_grant;
  int m_last;
  int m_words;
  int m_count;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_grant = 0;
    m_last  = N - 1;
    m_words = 0;
    m_count = 0;
    m_done  = 1'b0;
  endtask

  task automatic check_outputs();
    bit            stl;
    logic [N-1:0]  e_ready;
    logic          e_wen;
    logic [DW-1:0] e_wd;
    stl     = almost_full | full;
    e_ready = '0;
    e_wen   = 1'b0;
    e_wd    = '0;
    if (m_owner >= 0) begin
      if (!stl) e_ready[m_owner] = 1'b1;
      e_wen = req_valid[m_owner] && !stl;
      e_wd  = req_data[m_owner*DW +: DW];
    end
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("w_en", 32'(w_en), 32'(e_wen));
    check("w_data", 32'(w_data), 32'(e_wd));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("grant_id", 32'(grant_id), 32'(m_grant));
    check("burst_done", 32'(burst_done), 32'(m_done));
    check("word_count", 32'(word_count), 32'(m_count));
  endtask

  task automatic model_update();
    bit stl;
    bit wrote;
    stl    = almost_full | full;
    m_done = 1'b0;
    if (m_owner < 0) begin
      if (req_valid != '0 && !stl) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
        end
        m_grant = m_owner;
        m_words = 0;
      end
    end else begin
      wrote = req_valid[m_owner] && !stl;
      if (wrote) begin
        m_words++;
        if (m_count < (1 << CW) - 1) m_count++;
      end
      if ((wrote && m_words == MB) || !req_valid[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_done  = 1'b1;
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1 time unit later.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk_w);
    model_update();
    @(negedge clk_w);
  endtask

  task automatic apply_reset();
    rst_w = 1'b0;
    model_reset();
    #1;
    check("rst_w_en", 32'(w_en), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_word_count", 32'(word_count), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk_w);
    @(negedge clk_w);
    rst_w = 1'b1;
  endtask

  initial begin
    rst_w = 1'b0;
    req_valid = '0;
    req_data = '0;
    almost_full = 1'b0;
    full = 1'b0;
    model_reset();
    apply_reset();

    // Two requesters alternate with full bursts.
    req_valid = 4'b0101;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'h10 * (i + 1));
    repeat (10) step();
    check("s1_word_count", 32'(word_count), 32'(8));
    check("s1_grant", 32'(grant_id), 32'(2));
    repeat (6) step();

    // All requesters: grants rotate.
    req_valid = 4'b1111;
    repeat (25) step();

    // Requester 1 alone, stalled for 3 cycles mid-burst.
    req_valid = 4'b0000;
    repeat (2) step();
    req_valid = 4'b0010;
    repeat (3) step();
    almost_full = 1'b1;
    repeat (3) begin
      #1;
      check("s3_stall_wen", 32'(w_en), 32'(0));
      step();
    end
    almost_full = 1'b0;
    repeat (4) step();

    // Requester 3 drops valid after one word; pending requester 0 wins next.
    apply_reset();
    req_valid = 4'b1000;
    step();
    req_valid = 4'b1001;
    step();
    req_valid = 4'b0001;
    step();
    step();
    check("s4_grant0", 32'(grant_id), 32'(0));
    repeat (3) step();

    // full in IDLE holds off the grant.
    req_valid = 4'b0000;
    repeat (3) step();
    full = 1'b1;
    req_valid = 4'b0010;
    repeat (3) step();
    check("s5_idle_busy", 32'(busy), 32'(0));
    full = 1'b0;
    step();
    check("s5_grant", 32'(grant_id), 32'(1));
    repeat (3) step();

    // Asynchronous reset in the middle of a burst.
    apply_reset();
    req_valid = 4'b0100;
    repeat (3) step();
    rst_w = 1'b0;
    #1;
    check("s6_wen", 32'(w_en), 32'(0));
    check("s6_ready", 32'(req_ready), 32'(0));
    check("s6_count", 32'(word_count), 32'(0));
    model_reset();
    repeat (2) @(posedge clk_w);
    @(negedge clk_w);
    rst_w = 1'b1;
    req_valid = 4'b1111;
    step();
    check("s6_first_grant", 32'(grant_id), 32'(0));

    // Random traffic long enough to saturate the word counter.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_valid = N'($urandom);
      req_data    = (N*DW)'($urandom);
      almost_full = ($urandom_range(0, 7) == 0);
      full        = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
